// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// Holds the FSM states, status-byte bit positions and default geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_B0,
    S_B1,
    S_B2
  } state_t;

  localparam int SYNC_BIT  = 3;
  localparam int XSIGN_BIT = 4;
  localparam int YSIGN_BIT = 5;
  localparam int XOVF_BIT  = 6;
  localparam int YOVF_BIT  = 7;

  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_TIMEOUT = 100000;

  // Overflowed axes pin to the extreme of their sign.
  function automatic logic signed [8:0] sat_delta(
    input logic       sgn,
    input logic       ovf,
    input logic [7:0] mag
  );
    logic signed [8:0] d;
    d = '0;
    unique case (1'b1)
      ovf && sgn:  d = 9'h100;
      ovf && !sgn: d = 9'h0ff;
      !ovf:        d = {sgn, mag};
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ps2_cursor_accum.sv
// Clamped cursor accumulator: adds dx, subtracts dy (PS/2 +Y is up).
// Intermediates are wide enough that no sum can wrap.
module ps2_cursor_accum
  import ps2_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic signed [8:0]          dx,
  input  logic signed [8:0]          dy,
  output logic [$clog2(H_RES)-1:0]   cursor_x,
  output logic [$clog2(V_RES)-1:0]   cursor_y
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int CW = (XW > YW) ? XW : YW;
  localparam int AW = ((CW > 9) ? CW : 9) + 2;

  localparam logic signed [AW-1:0] XMAX = AW'(H_RES - 1);
  localparam logic signed [AW-1:0] YMAX = AW'(V_RES - 1);

  logic signed [AW-1:0] sx;
  logic signed [AW-1:0] sy;
  logic [XW-1:0]        nx;
  logic [YW-1:0]        ny;

  always_comb begin
    sx = $signed({{(AW-XW){1'b0}}, cursor_x})
       + $signed({{(AW-9){dx[8]}}, dx});
    sy = $signed({{(AW-YW){1'b0}}, cursor_y})
       - $signed({{(AW-9){dy[8]}}, dy});
    nx = sx[XW-1:0];
    ny = sy[YW-1:0];
    if (sx[AW-1])
      nx = '0;
    else if (sx > XMAX)
      nx = XW'(H_RES - 1);
    if (sy[AW-1])
      ny = '0;
    else if (sy > YMAX)
      ny = YW'(V_RES - 1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cursor_x <= XW'(H_RES / 2);
      cursor_y <= YW'(V_RES / 2);
    end else if (load) begin
      cursor_x <= nx;
      cursor_y <= ny;
    end
  end

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets into deltas, buttons and a cursor.
// Define PS2_MOUSE_TIMEOUT_EN to drop packets stalled mid-way.
module ps2_mouse_packet
  import ps2_pkg::*;
#(
  parameter int H_RES          = DEF_H_RES,
  parameter int V_RES          = DEF_V_RES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic signed [8:0]         dx,
  output logic signed [8:0]         dy,
  output logic [2:0]                buttons,
  output logic                      x_ovf,
  output logic                      y_ovf,
  output logic [$clog2(H_RES)-1:0]  cursor_x,
  output logic [$clog2(V_RES)-1:0]  cursor_y,
  output logic                      pkt_valid,
  output logic                      sync_err
);

  state_t state;
  state_t state_nxt;

  logic take_b0;
  logic take_x;
  logic take_y;
  logic discard;
  logic drop;
  logic tmo;

  logic       sx_r;
  logic       sy_r;
  logic       ox_r;
  logic       oy_r;
  logic [2:0] btn_r;
  logic [7:0] bx_r;

  logic signed [8:0] dx_new;
  logic signed [8:0] dy_new;

  always_comb begin
    state_nxt = state;
    take_b0   = 1'b0;
    take_x    = 1'b0;
    take_y    = 1'b0;
    discard   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      S_B0: begin
        if (in_valid) begin
          if (in_data[SYNC_BIT]) begin
            take_b0   = 1'b1;
            state_nxt = S_B1;
          end else begin
            discard = 1'b1;
          end
        end
      end
      S_B1: begin
        if (in_valid) begin
          take_x    = 1'b1;
          state_nxt = S_B2;
        end else if (tmo) begin
          drop      = 1'b1;
          state_nxt = S_B0;
        end
      end
      S_B2: begin
        if (in_valid) begin
          take_y    = 1'b1;
          state_nxt = S_B0;
        end else if (tmo) begin
          drop      = 1'b1;
          state_nxt = S_B0;
        end
      end
      default: state_nxt = S_B0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= S_B0;
    else
      state <= state_nxt;
  end

`ifdef PS2_MOUSE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign tmo = (state != S_B0) && (tcnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset_n)
      tcnt <= '0;
    else if (in_valid || state == S_B0 || tmo)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign tmo = 1'b0;
`endif

  // The Y byte is still on in_data when the packet completes.
  assign dx_new = sat_delta(sx_r, ox_r, bx_r);
  assign dy_new = sat_delta(sy_r, oy_r, in_data);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sx_r      <= 1'b0;
      sy_r      <= 1'b0;
      ox_r      <= 1'b0;
      oy_r      <= 1'b0;
      btn_r     <= '0;
      bx_r      <= '0;
      dx        <= '0;
      dy        <= '0;
      buttons   <= '0;
      x_ovf     <= 1'b0;
      y_ovf     <= 1'b0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      pkt_valid <= take_y;
      sync_err  <= discard | drop;
      if (take_b0) begin
        sx_r  <= in_data[XSIGN_BIT];
        sy_r  <= in_data[YSIGN_BIT];
        ox_r  <= in_data[XOVF_BIT];
        oy_r  <= in_data[YOVF_BIT];
        btn_r <= in_data[2:0];
      end
      if (take_x)
        bx_r <= in_data;
      if (take_y) begin
        dx      <= dx_new;
        dy      <= dy_new;
        buttons <= btn_r;
        x_ovf   <= ox_r;
        y_ovf   <= oy_r;
      end
    end
  end

  ps2_cursor_accum #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_accum (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (take_y),
    .dx       (dx_new),
    .dy       (dy_new),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Self-checking bench for ps2_mouse_packet: vector table, directed
// corner sequences and random bytes against a queue-based packet model.
module tb_ps2_mouse_packet;

  localparam int HR = 640;
  localparam int VR = 480;

  logic              clk;
  logic              reset_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic [2:0]        buttons;
  logic              x_ovf;
  logic              y_ovf;
  logic [9:0]        cursor_x;
  logic [8:0]        cursor_y;
  logic              pkt_valid;
  logic              sync_err;

  ps2_mouse_packet #(
    .H_RES          (HR),
    .V_RES          (VR),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .dx        (dx),
    .dy        (dy),
    .buttons   (buttons),
    .x_ovf     (x_ovf),
    .y_ovf     (y_ovf),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .pkt_valid (pkt_valid),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Behavioural model: bytes collected in a queue, packet decoded by rule.
  logic [7:0] mq[$];
  int m_dx, m_dy, m_btn, m_xo, m_yo, m_cx, m_cy;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] bx;
    logic [7:0] by;
    int dx, dy, btn, xo, yo, cx, cy;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(input logic sgn, input logic ovf,
                               input logic [7:0] b);
    if (ovf) return sgn ? -256 : 255;
    return sgn ? int'(b) - 256 : int'(b);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dx = 0; m_dy = 0; m_btn = 0; m_xo = 0; m_yo = 0;
    m_cx = HR / 2;
    m_cy = VR / 2;
  endtask

  task automatic model_step(input logic [7:0] b, output bit e_pkt,
                            output bit e_err);
    logic [7:0] s;
    e_pkt = 0;
    e_err = 0;
    if (mq.size() == 0 && !b[3]) begin
      e_err = 1;
    end else begin
      mq.push_back(b);
      if (mq.size() == 3) begin
        s     = mq[0];
        m_dx  = delta(s[4], s[6], mq[1]);
        m_dy  = delta(s[5], s[7], mq[2]);
        m_btn = int'(s[2:0]);
        m_xo  = int'(s[6]);
        m_yo  = int'(s[7]);
        m_cx  = clamp(m_cx + m_dx, HR - 1);
        m_cy  = clamp(m_cy - m_dy, VR - 1);
        mq.delete();
        e_pkt = 1;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, " dx"}, int'(dx), m_dx);
    chk({tag, " dy"}, int'(dy), m_dy);
    chk({tag, " buttons"}, int'(buttons), m_btn);
    chk({tag, " x_ovf"}, int'(x_ovf), m_xo);
    chk({tag, " y_ovf"}, int'(y_ovf), m_yo);
    chk({tag, " cursor_x"}, int'(cursor_x), m_cx);
    chk({tag, " cursor_y"}, int'(cursor_y), m_cy);
  endtask

  task automatic send(input logic [7:0] b);
    bit ep, ee;
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_step(b, ep, ee);
    chk("pkt_valid", int'(pkt_valid), int'(ep));
    chk("sync_err", int'(sync_err), int'(ee));
    check_outs("send");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("idle pkt_valid", int'(pkt_valid), 0);
      chk("idle sync_err", int'(sync_err), 0);
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h08;
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    model_reset();
    chk("rst pkt_valid", int'(pkt_valid), 0);
    chk("rst sync_err", int'(sync_err), 0);
    check_outs("rst");
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();

    tbl[0]  = '{8'h08, 8'h05, 8'h03,    5,    3, 0, 0, 0, 325, 237};
    tbl[1]  = '{8'h19, 8'hfb, 8'h00,   -5,    0, 1, 0, 0, 320, 237};
    tbl[2]  = '{8'h18, 8'h00, 8'h00, -256,    0, 0, 0, 0,  64, 237};
    tbl[3]  = '{8'h18, 8'h00, 8'h00, -256,    0, 0, 0, 0,   0, 237};
    tbl[4]  = '{8'h18, 8'h80, 8'h00, -128,    0, 0, 0, 0,   0, 237};
    tbl[5]  = '{8'h48, 8'h10, 8'h00,  255,    0, 0, 1, 0, 255, 237};
    tbl[6]  = '{8'ha8, 8'h00, 8'h01,    0, -256, 0, 0, 1, 255, 479};
    tbl[7]  = '{8'h0f, 8'h7f, 8'h7f,  127,  127, 7, 0, 0, 382, 352};
    tbl[8]  = '{8'h08, 8'h00, 8'hff,    0,  255, 0, 0, 0, 382,  97};
    tbl[9]  = '{8'h08, 8'h00, 8'hff,    0,  255, 0, 0, 0, 382,   0};
    tbl[10] = '{8'h48, 8'h00, 8'h00,  255,    0, 0, 1, 0, 637,   0};
    tbl[11] = '{8'h48, 8'h00, 8'h00,  255,    0, 0, 1, 0, 639,   0};

    do_reset();
    chk("rst cursor_x const", int'(cursor_x), 320);
    chk("rst cursor_y const", int'(cursor_y), 240);

    // Table: rows sent back-to-back, some with idle gaps.
    for (int r = 0; r < 12; r++) begin
      send(tbl[r].b0);
      send(tbl[r].bx);
      send(tbl[r].by);
      chk($sformatf("tbl%0d pkt", r), int'(pkt_valid), 1);
      chk($sformatf("tbl%0d dx", r), int'(dx), tbl[r].dx);
      chk($sformatf("tbl%0d dy", r), int'(dy), tbl[r].dy);
      chk($sformatf("tbl%0d btn", r), int'(buttons), tbl[r].btn);
      chk($sformatf("tbl%0d xovf", r), int'(x_ovf), tbl[r].xo);
      chk($sformatf("tbl%0d yovf", r), int'(y_ovf), tbl[r].yo);
      chk($sformatf("tbl%0d cx", r), int'(cursor_x), tbl[r].cx);
      chk($sformatf("tbl%0d cy", r), int'(cursor_y), tbl[r].cy);
      if (r[0]) idle(2);
    end

    // Reset after two bytes of a packet drops them silently.
    do_reset();
    send(8'h08);
    send(8'h05);
    do_reset();
    idle(1);
    send(8'h08);
    send(8'h01);
    send(8'h00);
    chk("midrst cursor_x", int'(cursor_x), 321);
    chk("midrst cursor_y", int'(cursor_y), 240);

    // Out-of-sync byte, then a good packet.
    idle(1);
    send(8'h05);
    chk("resync err", int'(sync_err), 1);
    idle(1);
    send(8'h08);
    send(8'h01);
    send(8'h01);
    chk("resync dx", int'(dx), 1);
    chk("resync dy", int'(dy), 1);
    idle(1);

`ifdef PS2_MOUSE_TIMEOUT_EN
    begin
      int errs;
      int pkts;
      do_reset();
      send(8'h08);
      send(8'h05);
      errs = 0;
      pkts = 0;
      for (int i = 0; i < 60; i++) begin
        @(posedge clk);
        #1;
        errs += int'(sync_err);
        pkts += int'(pkt_valid);
      end
      mq.delete();
      chk("tmo sync_err count", errs, 1);
      chk("tmo pkt count", pkts, 0);
      send(8'h08);
      send(8'h02);
      send(8'h00);
      chk("tmo dx", int'(dx), 2);
    end
`endif

    // Random bytes, mostly well-framed, with random gaps.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (mq.size() == 0 && $urandom_range(0, 9) != 0)
        b[3] = 1'b1;
      send(b);
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet.md
PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

Interface
REQ-001 Parameter H_RES, default 640, horizontal cursor range; cursor_x spans 0..H_RES-1.
REQ-002 Parameter V_RES, default 480, vertical cursor range; cursor_y spans 0..V_RES-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000 (2 ms at 50 MHz), inter-byte timeout; used only when PS2_MOUSE_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 in_data  in  8  byte from the PS/2 receiver stage.
REQ-007 in_valid  in  1  one-cycle strobe; in_data is valid while in_valid is high.
REQ-008 dx, dy  out  9  signed movement of the last packet: {sign, byte}.
REQ-009 buttons  out  3  {middle, right, left} from byte0[2:0].
REQ-010 x_ovf, y_ovf  out  1  overflow flags of the last packet.
REQ-011 cursor_x  out  $clog2(H_RES)  clamped cursor column.
REQ-012 cursor_y  out  $clog2(V_RES)  clamped cursor row.
REQ-013 pkt_valid  out  1  one-cycle pulse; dx, dy, buttons, ovf and cursor are updated.
REQ-014 sync_err  out  1  one-cycle pulse when a byte or partial packet is discarded.

Function
REQ-015 The FSM SHALL have exactly three states: S_B0 (await status byte), S_B1 (await X), S_B2 (await Y).
REQ-016 S_B0 with in_valid: if in_data[3]==1, capture it and go to S_B1; otherwise discard it, stay in S_B0 and pulse sync_err on the next cycle.
REQ-017 S_B1 with in_valid: capture the X byte and go to S_B2. S_B2 with in_valid: capture the Y byte and go to S_B0.
REQ-018 Cycles without in_valid SHALL hold the current state, apart from the timeout in REQ-029.
REQ-019 pkt_valid SHALL assert exactly one cycle after the clock edge that captures the Y byte; all outputs update on that same edge.
REQ-020 dx = {b0[4], X} and dy = {b0[5], Y}, as 9-bit two's complement. x_ovf = b0[6] and y_ovf = b0[7].
REQ-021 If x_ovf is set, dx SHALL saturate to +255 when b0[4]==0 and to -256 when b0[4]==1. dy and y_ovf follow the same rule.
REQ-022 cursor_x_next = clamp(cursor_x + dx, 0, H_RES-1).
REQ-023 cursor_y_next = clamp(cursor_y - dy, 0, V_RES-1); PS/2 +Y means up on screen.
REQ-024 Cursor arithmetic SHALL use signed intermediates at least 2 bits wider than the cursor, so no wrap-around occurs.
REQ-025 An in_valid in the same cycle that pkt_valid is high SHALL be processed normally; no byte is lost.

Reset
REQ-026 Reset SHALL take effect on the clock edge while reset_n is low.
REQ-027 Reset values: state S_B0; dx, dy, buttons, x_ovf, y_ovf, pkt_valid and sync_err = 0; cursor_x = H_RES/2; cursor_y = V_RES/2; timeout counter = 0.
REQ-028 Reset mid-packet SHALL discard partial bytes without pulsing sync_err. in_valid during reset SHALL be ignored.

Configuration
REQ-029 With PS2_MOUSE_TIMEOUT_EN defined:
- A counter clears on every in_valid and counts while in S_B1 or S_B2.
- When it reaches TIMEOUT_CYCLES, the FSM returns to S_B0, the partial packet is dropped and sync_err pulses once.
REQ-030 Without PS2_MOUSE_TIMEOUT_EN, no counter SHALL be synthesised, and S_B1 and S_B2 wait indefinitely.

Structure
REQ-031 Shared package ps2_pkg SHALL hold the FSM state enum, the status-byte bit positions (sync, sign, overflow) and the default H_RES/V_RES/TIMEOUT_CYCLES constants.
REQ-032 Sub-module ps2_cursor_accum SHALL implement the clamped accumulator (REQ-022 to REQ-024), with a load strobe, dx/dy inputs and cursor outputs.

Verification
REQ-033 After reset, send 0x08, 0x05, 0x03 -> one pkt_valid; dx=+5, dy=+3, buttons=0, cursor=(325,237).
REQ-034 Send 0x19, 0xFB, 0x00 -> dx=-5, buttons=3'b001, cursor_x decreases by 5.
REQ-035 Drive the cursor to x=0, then send 0x18, 0x80, 0x00 -> cursor_x stays 0. Send 0x48, 0x10, 0x00 -> x_ovf=1, dx=+255.
REQ-036 Send 0x05, then 0x08, 0x01, 0x01 -> one sync_err pulse for 0x05, then a valid packet with dx=+1, dy=+1.
REQ-037 (TIMEOUT_EN, TIMEOUT_CYCLES=50) Send 0x08, 0x05, idle 60 cycles, then 0x08, 0x02, 0x00:
- sync_err pulses once;
- the next packet gives dx=+2 (not +5).
REQ-038 Assert reset_n=0 after two bytes of a packet, release, then send 0x08, 0x01, 0x00 -> cursor=(321,240), no sync_err.
